// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED/switch matrix blocks: scan FSM states and the
// (row pin, column) -> cell bit mapping used by both the scanner and the LED driver.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } scan_state_t;

  // Row pin 0 is the bottom row of the array, so it lands in the top cell row.
  function automatic int cell_idx(input int n, input int row_pin, input int col);
    return (n - 1 - row_pin) * n + col;
  endfunction

endpackage

// File: rtl/decoder_3_to_8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder_3_to_8 (
  input  logic       ena,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  assign y = ena ? (8'd1 << sel) : 8'd0;

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Plain double-register; no reset so the chain never gates metastability settling.
  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/switch_matrix_scanner.sv
// NxN switch matrix scanner: drives one column at a time, samples the synchronized
// row lines, and commits a debounced N*N cell image once enough identical frames
// have been seen in a row.
module switch_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int N               = 8,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N-1:0]     rows,
  output logic [N-1:0]     cols,
  output logic [$clog2(N):0] x,
  output logic [N*N-1:0]   cells,
  output logic             frame_done,
  output logic             cells_changed
);

  localparam int XW = $clog2(N) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES);

  localparam logic [1:0]    ST_IDLE     = 2'(IDLE);
  localparam logic [1:0]    ST_SCAN     = 2'(SCAN);
  localparam logic [1:0]    ST_COMMIT   = 2'(COMMIT);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST      = XW'(N - 1);
  localparam logic [3:0]    DEB         = 4'(DEBOUNCE_FRAMES);

  if (N < 1 || N > 8) begin : g_bad_n
    $error("switch_matrix_scanner: N must be in 1..8");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("switch_matrix_scanner: SETTLE_CYCLES must be >= 3 to cover the synchronizer lag");
  end
  if (DEBOUNCE_FRAMES < 0 || DEBOUNCE_FRAMES > 15) begin : g_bad_deb
    $error("switch_matrix_scanner: DEBOUNCE_FRAMES must be in 0..15");
  end

  logic [1:0]     state;
  logic [SW-1:0]  settle_cnt;
  logic [3:0]     stable_cnt;
  logic [3:0]     stable_next;
  logic [N*N-1:0] raw, raw_prev, raw_next;
  logic [N-1:0]   rows_sync;
  logic [7:0]     dec_y;
  logic [2:0]     col_sel;
  logic           sample;
  logic           commit_ok;

  sync_2ff #(.W(N)) u_sync (
    .clk (clk),
    .d   (rows),
    .q   (rows_sync)
  );

  assign col_sel = 3'(x);

  decoder_3_to_8 u_dec (
    .ena (state == ST_SCAN),
    .sel (col_sel),
    .y   (dec_y)
  );

  assign cols = dec_y[N-1:0];

  // Last settle cycle of the current column: latch that column's row pins.
  // An ena drop in the same cycle wins, so a sample is never taken on the way out.
  assign sample = (state == ST_SCAN) && ena && (settle_cnt == SETTLE_LAST);

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      // Rows are active-low: a closed switch reads back as 0, stored as 1.
      assign raw_next[cell_idx(N, r, c)] =
        (sample && x == XW'(c)) ? ~rows_sync[r] : raw[cell_idx(N, r, c)];
    end
  end

  // Count of consecutive identical frames, saturating at DEB; a differing frame restarts it.
  assign stable_next = (raw != raw_prev) ? 4'd0 :
                       (stable_cnt >= DEB) ? DEB : stable_cnt + 4'd1;
  assign commit_ok   = (stable_next >= DEB);

  // Scan sequencing, frame assembly and debounced commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      x             <= '0;
      settle_cnt    <= '0;
      stable_cnt    <= '0;
      raw           <= '0;
      raw_prev      <= '0;
      cells         <= '0;
      frame_done    <= 1'b0;
      cells_changed <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      cells_changed <= 1'b0;
      raw           <= raw_next;
      case (state)
        ST_IDLE: begin
          if (ena) begin
            state      <= ST_SCAN;
            x          <= '0;
            settle_cnt <= '0;
          end
        end
        ST_SCAN: begin
          if (!ena) begin
            // Abandon the partial frame; debounce history restarts on re-enable.
            state      <= ST_IDLE;
            x          <= '0;
            settle_cnt <= '0;
            stable_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            if (x == X_LAST) begin
              x     <= '0;
              state <= ST_COMMIT;
            end else begin
              x <= x + XW'(1);
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_COMMIT: begin
          stable_cnt <= stable_next;
          raw_prev   <= raw;
          if (commit_ok) begin
            cells         <= raw;
            cells_changed <= (raw != cells);
          end
          frame_done <= 1'b1;
          state      <= ena ? ST_SCAN : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
